// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one byte-wide UART TX channel between N_PORTS requesters, round-robin, one whole line per grant.
// Latency: 1 cycle to arbitrate, then an optional tag byte, then payload passes through combinationally (0 cycles).
// Backpressure: serial_out_ready goes straight back to the granted req_ready. Stalls hold the grant and never time out.
//
// Ports:
//   clock, reset         - clock; asynchronous active-high reset
//   req_valid/req_ready  - per-requester byte handshake (one bit per port)
//   req_bits             - requester i drives bits [8i+7:8i]
//   serial_out_*         - single byte stream toward the UART
//   grant_valid/_idx     - current owner of the channel (idx is 0 when no grant)
module uart_tx_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 16,
  parameter int TAG_EN       = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_PORTS-1:0]              req_valid,
  output logic [N_PORTS-1:0]              req_ready,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   req_bits,
  output logic                            serial_out_valid,
  input  logic                            serial_out_ready,
  output logic [DATA_WIDTH-1:0]           serial_out_bits,
  output logic                            grant_valid,
  output logic [$clog2(N_PORTS)-1:0]      grant_idx
);

  localparam int GW = $clog2(N_PORTS);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_PASS} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_idx_q, grant_idx_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            grant_valid_q, grant_valid_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

  logic [DATA_WIDTH-1:0] req_byte [N_PORTS];
  logic                  found;
  logic [GW-1:0]         winner;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_bits;
  logic                  release_line;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign req_byte[i] = req_bits[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin : rr_search
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req_valid[GW'(idx)]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  assign sel_valid = req_valid[grant_idx_q];
  assign sel_bits  = req_byte[grant_idx_q];

  always_comb begin
    state_d          = state_q;
    grant_idx_d      = grant_idx_q;
    rr_ptr_d         = rr_ptr_q;
    grant_valid_d    = grant_valid_q;
    burst_cnt_d      = burst_cnt_q;
    idle_cnt_d       = idle_cnt_q;
    release_line     = 1'b0;
    serial_out_valid = 1'b0;
    serial_out_bits  = '0;
    req_ready        = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_idx_d   = winner;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          idle_cnt_d    = '0;
          state_d       = (TAG_EN != 0) ? ST_TAG : ST_PASS;
        end
      end

      ST_TAG: begin
        serial_out_valid = 1'b1;
        serial_out_bits  = 8'h30 + 8'(grant_idx_q);
        if (serial_out_ready) state_d = ST_PASS;
      end

      ST_PASS: begin
        serial_out_valid       = sel_valid;
        serial_out_bits        = sel_bits;
        req_ready[grant_idx_q] = serial_out_ready;
        if (sel_valid) begin
          // A stalled but valid requester is still busy, so the idle count restarts.
          idle_cnt_d = '0;
          if (serial_out_ready) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
            if (sel_bits == 8'h0A || burst_cnt_q == BW'(MAX_BURST - 1))
              release_line = 1'b1;
          end
        end else begin
          if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1))
            release_line = 1'b1;
          else
            idle_cnt_d = idle_cnt_q + IW'(1);
        end

        // Newline and burst limit on the same byte still give a single release.
        if (release_line) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          burst_cnt_d   = '0;
          idle_cnt_d    = '0;
          if (grant_idx_q == GW'(N_PORTS - 1))
            rr_ptr_d = '0;
          else
            rr_ptr_d = grant_idx_q + GW'(1);
        end
      end

      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_bits;
  logic           serial_out_valid;
  logic           serial_out_ready;
  logic [7:0]     serial_out_bits;
  logic           grant_valid;
  logic [1:0]     grant_idx;

  uart_tx_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(8), .MAX_BURST(4), .IDLE_TIMEOUT(16), .TAG_EN(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_bits(req_bits),
    .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
    .serial_out_bits(serial_out_bits),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] idx;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] src [N][$];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle samples taken at the falling edge.
  logic [N-1:0] fire_s;
  logic [N-1:0] rdy_s;
  logic         gv_s, gv_prev = 1'b0;
  logic [1:0]   gidx_s, gidx_prev = 2'd0;
  int           gv_cnt = 0, grant_cnt = 0, nogap = 0, bad_rdy = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src[i].size() != 0) begin
        req_valid[i]       = 1'b1;
        req_bits[i*8 +: 8] = src[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_bits[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input int p);
    exp_t e;
    e.b   = b;
    e.idx = 2'(p);
    exp_q.push_back(e);
  endtask

  // Queue a tagged line on port p and the bytes the UART should see for it.
  task automatic push_line(input int p, input string s);
    push_exp(8'h30 + 8'(p), p);
    for (int k = 0; k < s.len(); k++) begin
      src[p].push_back(s[k]);
      push_exp(s[k], p);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    fire_s = req_valid & req_ready;
    rdy_s  = req_ready;
    gv_s   = grant_valid;
    gidx_s = grant_idx;
    if (gv_s) gv_cnt++;
    if (gv_s && !gv_prev) grant_cnt++;
    if (gv_s && gv_prev && gidx_s != gidx_prev) nogap++;
    if (gv_s && gidx_s == 2'd0 && rdy_s[1]) bad_rdy++;
    gv_prev   = gv_s;
    gidx_prev = gidx_s;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++)
      if (fire_s[i]) void'(src[i].pop_front());
    drive();
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0 &&
          src[3].size() == 0 && !gv_s)
        return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  // Scoreboard monitor: every transfer must match the next expected byte and owner.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && serial_out_valid && serial_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", int'(serial_out_bits), 'h100);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", int'(serial_out_bits), int'(e.b));
          check("out_owner", int'(grant_idx), int'(e.idx));
        end
      end
    end
  end

  initial begin
    int n;
    reset            = 1'b1;
    serial_out_ready = 1'b1;
    req_valid        = '0;
    req_bits         = '0;
    repeat (2) tick();
    check("rst_grant_valid", int'(grant_valid), 0);
    check("rst_grant_idx", int'(grant_idx), 0);
    check("rst_out_valid", int'(serial_out_valid), 0);
    check("rst_out_bits", int'(serial_out_bits), 0);
    check("rst_req_ready", int'(req_ready), 0);
    reset = 1'b0;
    tick();

    // Contention: ports 0 and 1 together, pointer at 0.
    grant_cnt = 0; nogap = 0; bad_rdy = 0;
    push_line(0, "ab\n");
    push_line(1, "ab\n");
    drive();
    wait_idle(40);
    check("cont_grants", grant_cnt, 2);
    check("cont_idle_gap", nogap, 0);
    check("cont_p1_ready_during_p0", bad_rdy, 0);

    // Single line from port 2: tag + 3 bytes = 4 granted cycles.
    gv_cnt = 0;
    push_line(2, "hi\n");
    drive();
    wait_idle(40);
    check("single_grant_cycles", gv_cnt, 4);

    // Pointer should now be 3, so port 3 beats port 0.
    push_line(3, "z\n");
    push_line(0, "z\n");
    drive();
    wait_idle(40);

    // Burst limit 4: 10 bytes become 4+4+2 with a fresh tag each time.
    grant_cnt = 0; nogap = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 4 == 0) push_exp(8'h33, 3);
      src[3].push_back(8'h41 + 8'(k));
      push_exp(8'h41 + 8'(k), 3);
    end
    drive();
    wait_idle(80);
    check("burst_grants", grant_cnt, 3);
    check("burst_idle_gap", nogap, 0);

    // Idle timeout: port 1 sends 'x' then goes quiet while port 0 waits.
    push_exp(8'h31, 1);
    push_exp(8'h78, 1);
    src[1].push_back(8'h78);
    drive();
    n = 0;
    for (int i = 0; i < 10 && !fire_s[1]; i++) tick();
    check("idle_x_sent", int'(fire_s[1]), 1);
    push_line(0, "ok\n");
    drive();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gv_s && gidx_s == 2'd1) n++;
      else break;
    end
    check("idle_release_cycles", n, 16);
    wait_idle(40);

    // Backpressure: hold the tag, then stall the payload, for 20 cycles each.
    serial_out_ready = 1'b0;
    push_line(2, "q\n");
    drive();
    tick();
    for (int i = 0; i < 20; i++) begin
      check("bp_tag_valid", int'(serial_out_valid), 1);
      check("bp_tag_bits", int'(serial_out_bits), 'h32);
      tick();
    end
    serial_out_ready = 1'b1;
    tick();
    serial_out_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("bp_stall_no_timeout", int'(gv_s), 1);
    check("bp_stall_ready_low", int'(rdy_s), 0);
    serial_out_ready = 1'b1;
    wait_idle(40);

    // Async reset mid-line, then arbitration restarts from port 0.
    push_line(0, "ab\n");
    drive();
    repeat (3) tick();
    check("pre_reset_out_valid", int'(serial_out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(serial_out_valid), 0);
    check("midrst_req_ready", int'(req_ready), 0);
    check("midrst_grant_valid", int'(grant_valid), 0);
    for (int i = 0; i < N; i++) src[i].delete();
    exp_q.delete();
    drive();
    repeat (2) tick();
    reset = 1'b0;
    push_line(1, "r\n");
    push_line(3, "s\n");
    drive();
    wait_idle(40);

    check("final_drain", exp_q.size(), 0);
    check("final_grant_valid", int'(grant_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmit channel (serial_out valid/ready/bits, feeding the simulated UART model) between N_PORTS requesters, e.g. multiple harts' console streams.
- Grants are round-robin and line-atomic: a grant is held until newline, burst limit or idle timeout, so lines from different requesters never interleave.
- With TAG_EN=1, each grant is prefixed with one ASCII tag byte identifying the requester.

Parameters:
N_PORTS, 4, number of requesters; legal range 2..10 (tag is one ASCII digit)
DATA_WIDTH, 8, byte width; fixed at 8
MAX_BURST, 64, max payload bytes per grant; legal range >=1
IDLE_TIMEOUT, 16, consecutive cycles with granted valid low before forced release; legal range >=1
TAG_EN, 1, 1 = emit tag byte 0x30+index at grant start

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  N_PORTS  per-requester byte valid
req_ready  out  N_PORTS  per-requester byte accepted
req_bits  in  N_PORTS*8  requester i occupies bits [8i+7:8i]
serial_out_valid  out  1  byte to UART valid
serial_out_ready  in  1  UART accepts byte
serial_out_bits  out  8  byte to UART
grant_valid  out  1  a requester currently owns the channel
grant_idx  out  clog2(N_PORTS)  owning requester; 0 when grant_valid=0

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0, idle_cnt=0. All outputs 0 while reset is high, including mid-burst. Any in-flight line is abandoned and no tag is pending.
- Transfer = serial_out_valid & serial_out_ready.
- States: IDLE, TAG, PASS.
- IDLE
  - serial_out_valid=0, req_ready=0, grant_valid=0.
  - If any req_valid is set, grant the first asserted index searching rr_ptr, rr_ptr+1, ... with wrap mod N_PORTS.
  - Next cycle: grant_idx=winner, grant_valid=1, burst_cnt=0, idle_cnt=0, state=TAG (TAG_EN=1) or PASS (TAG_EN=0).
  - Arbitration latency is 1 cycle; the first payload byte can transfer no earlier than cycle 2 after req_valid rises (cycle 3 with a tag).
- TAG
  - serial_out_valid=1, serial_out_bits=0x30+grant_idx, req_ready=0.
  - Outputs are held stable while serial_out_ready=0.
  - On transfer, go to PASS. The tag does not count toward burst_cnt.
- PASS (combinational pass-through)
  - serial_out_valid=req_valid[grant_idx]; serial_out_bits=req_bits[grant_idx]; req_ready[grant_idx]=serial_out_ready; all other req_ready=0.
  - On transfer: burst_cnt++, idle_cnt=0.
  - Release on the transfer cycle if the byte is 0x0A, or if burst_cnt==MAX_BURST-1 (i.e. that was the MAX_BURST-th byte).
  - When req_valid[grant_idx]=0: idle_cnt++. When req_valid[grant_idx]=1 with serial_out_ready=0 (stall): idle_cnt=0; stalls never time out.
  - Release when idle_cnt reaches IDLE_TIMEOUT-1 while req_valid[grant_idx]=0, i.e. release after IDLE_TIMEOUT idle cycles.
- Release
  - Next cycle: state=IDLE, grant_valid=0, grant_idx=0, rr_ptr=(old grant_idx+1) mod N_PORTS.
  - There is always at least one IDLE cycle between grants, including when the same requester is re-granted.
- Simultaneous newline and MAX_BURST on the same byte: single release; rr_ptr advances once.
- A requester's req_valid dropping without a transfer is legal (no AXI-style valid hold required); it only feeds the idle timeout.
- Only one requester can ever have req_ready=1, so bytes are never duplicated or dropped.

Test Plan:
- Single line, TAG_EN=1: port 2 sends "hi\n" with serial_out_ready=1 -> UART sees 0x32,0x68,0x69,0x0A; grant_valid high for 4 cycles; rr_ptr=3 afterwards.
- Contention: ports 0 and 1 both send "ab\n" from cycle 0, rr_ptr=0 -> output 0x30,'a','b',0x0A, one IDLE cycle, then 0x31,'a','b',0x0A. Port 1 req_ready stays 0 throughout the first line.
- Burst limit: MAX_BURST=4, port 3 streams 10 bytes with no newline, other ports idle -> grant released after 4 payload bytes; port 3 re-granted with a new tag; bytes arrive in order, total 3 tags (4+4+2).
- Idle timeout: IDLE_TIMEOUT=16, port 1 sends 'x' then drops valid, port 0 is valid -> port 1 released exactly 16 cycles after 'x'; port 0 granted next.
- Backpressure: serial_out_ready=0 for 20 cycles during TAG and during PASS with valid high -> tag byte stable, no timeout, no data loss; 0x0A still releases.
- Async reset mid-line: assert reset between clock edges during PASS -> serial_out_valid, req_ready, grant_valid go 0 immediately; after release, arbitration restarts from port 0.
